// File: rtl/eeprom_page_program_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_page_program_ctrl_pkg
// Brief    : Opcodes, status bit index and state encoding for the page programmer.
// Revision : 1.0
// ============================================================================
package eeprom_page_program_ctrl_pkg;

    localparam logic [7:0] c_opc_wren  = 8'h06;
    localparam logic [7:0] c_opc_pp    = 8'h02;
    localparam logic [7:0] c_opc_rdsr  = 8'h05;
    localparam logic [7:0] c_dummy     = 8'h00;
    localparam int         c_wip_bit   = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_GAP      = 4'd1,
        ST_WREN_TX  = 4'd2,
        ST_PP_CMD   = 4'd3,
        ST_PP_ADDR  = 4'd4,
        ST_PP_DATA  = 4'd5,
        ST_POLL_CMD = 4'd6,
        ST_POLL_RD  = 4'd7,
        ST_NEXT     = 4'd8,
        ST_FINISH   = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/eeprom_page_program_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_page_program_ctrl_if
// Brief    : Byte-level SPI master handshake plus device chip select.
// Revision : 1.0
// ============================================================================
interface eeprom_page_program_ctrl_if;

    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_done;
    logic [7:0] spi_rx;
    logic       nCS;

    modport master (output spi_start, output spi_tx, output nCS,
                    input  spi_done,  input  spi_rx);
    modport slave  (input  spi_start, input  spi_tx, input  nCS,
                    output spi_done,  output spi_rx);

endinterface
`default_nettype wire

// File: rtl/eeprom_page_program_ctrl_spi_cmd_seq_cnt.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_seq_cnt
// Brief    : Shared down-counter for byte counts and the chip-select gap timer.
// Revision : 1.0
// ============================================================================
module spi_cmd_seq_cnt #(
    parameter int WIDTH = 9
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              i_load,
    input  wire [WIDTH-1:0]  i_load_val,
    input  wire              i_dec,
    output logic             o_last
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_last = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/eeprom_page_program_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_page_program_ctrl
// Brief    : Programs N consecutive pages: WREN, PP + address + data, RDSR poll.
// Revision : 1.0
// ============================================================================
module eeprom_page_program_ctrl
    import eeprom_page_program_ctrl_pkg::*;
#(
    parameter int ADDR_BYTES = 3,
    parameter int PAGE_BYTES = 256,
    parameter int POLL_LIMIT = 65535,
    parameter int CS_GAP     = 2
) (
    input  wire                              clk,
    input  wire                              rst,
    input  wire                              start,
    input  wire [8*ADDR_BYTES-1:0]           base_addr,
    input  wire [15:0]                       num_pages,
    eeprom_page_program_ctrl_if.master       spi,
    output logic [$clog2(PAGE_BYTES)-1:0]    buf_addr,
    input  wire [7:0]                        buf_data,
    output logic                             page_done,
    output logic                             busy,
    output logic                             error
);

    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int BUF_W  = $clog2(PAGE_BYTES);
    localparam int GAP_W  = $clog2(CS_GAP + 1);
    localparam int CNT_W  = (BUF_W + 1 > GAP_W) ? BUF_W + 1 : GAP_W;
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);

    localparam logic [CNT_W-1:0]  c_gap_load  = CNT_W'(CS_GAP);
    localparam logic [CNT_W-1:0]  c_addr_load = CNT_W'(ADDR_BYTES);
    localparam logic [CNT_W-1:0]  c_page_load = CNT_W'(PAGE_BYTES);
    localparam logic [POLL_W-1:0] c_poll_lim  = POLL_W'(POLL_LIMIT);

    state_t              r_state, w_state, r_after_gap, w_after_gap;
    logic                r_wait, w_wait;
    logic [ADDR_W-1:0]   r_page_addr, w_page_addr, r_addr_sh, w_addr_sh;
    logic [15:0]         r_pages_left, w_pages_left;
    logic [POLL_W-1:0]   r_poll_cnt, w_poll_cnt, w_poll_inc;
    logic                r_ncs, w_ncs, r_spi_start, w_spi_start;
    logic [7:0]          r_spi_tx, w_spi_tx;
    logic [BUF_W-1:0]    r_buf_addr, w_buf_addr;
    logic                r_page_done, w_page_done, r_busy, w_busy, r_error, w_error;
    logic                w_cnt_load, w_cnt_dec, w_cnt_last, w_done;
    logic [CNT_W-1:0]    w_cnt_val;

    spi_cmd_seq_cnt #(.WIDTH(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_last     (w_cnt_last)
    );

    // A done is only honoured once our spi_start has been seen by the master.
    assign w_done     = spi.spi_done && r_wait && !r_spi_start;
    assign w_poll_inc = r_poll_cnt + POLL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_after_gap  <= ST_IDLE;
            r_wait       <= 1'b0;
            r_page_addr  <= '0;
            r_addr_sh    <= '0;
            r_pages_left <= '0;
            r_poll_cnt   <= '0;
            r_ncs        <= 1'b1;
            r_spi_start  <= 1'b0;
            r_spi_tx     <= '0;
            r_buf_addr   <= '0;
            r_page_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_after_gap  <= w_after_gap;
            r_wait       <= w_wait;
            r_page_addr  <= w_page_addr;
            r_addr_sh    <= w_addr_sh;
            r_pages_left <= w_pages_left;
            r_poll_cnt   <= w_poll_cnt;
            r_ncs        <= w_ncs;
            r_spi_start  <= w_spi_start;
            r_spi_tx     <= w_spi_tx;
            r_buf_addr   <= w_buf_addr;
            r_page_done  <= w_page_done;
            r_busy       <= w_busy;
            r_error      <= w_error;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_after_gap  = r_after_gap;
        w_wait       = r_wait;
        w_page_addr  = r_page_addr;
        w_addr_sh    = r_addr_sh;
        w_pages_left = r_pages_left;
        w_poll_cnt   = r_poll_cnt;
        w_ncs        = r_ncs;
        w_spi_start  = 1'b0;
        w_spi_tx     = r_spi_tx;
        w_buf_addr   = r_buf_addr;
        w_page_done  = 1'b0;
        w_error      = r_error;
        w_cnt_load   = 1'b0;
        w_cnt_val    = c_gap_load;
        w_cnt_dec    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !r_busy) begin
                    w_page_addr  = base_addr;
                    w_pages_left = num_pages;
                    w_error      = 1'b0;
                    w_buf_addr   = '0;
                    if (num_pages == 16'd0) begin
                        w_state = ST_FINISH;
                    end else begin
                        w_state     = ST_GAP;
                        w_after_gap = ST_WREN_TX;
                        w_cnt_load  = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_last) begin
                    w_state = r_after_gap;
                    w_ncs   = 1'b0;
                    w_wait  = 1'b0;
                end
            end
            ST_WREN_TX: begin
                if (!r_wait) begin
                    w_spi_start = 1'b1;
                    w_spi_tx    = c_opc_wren;
                    w_wait      = 1'b1;
                end else if (w_done) begin
                    w_ncs       = 1'b1;
                    w_state     = ST_GAP;
                    w_after_gap = ST_PP_CMD;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_PP_CMD: begin
                if (!r_wait) begin
                    w_spi_start = 1'b1;
                    w_spi_tx    = c_opc_pp;
                    w_wait      = 1'b1;
                end else if (w_done) begin
                    w_state    = ST_PP_ADDR;
                    w_wait     = 1'b0;
                    w_addr_sh  = r_page_addr;
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_addr_load;
                end
            end
            ST_PP_ADDR: begin
                if (!r_wait) begin
                    w_spi_start = 1'b1;
                    w_spi_tx    = r_addr_sh[ADDR_W-1 -: 8];
                    w_addr_sh   = r_addr_sh << 8;
                    w_wait      = 1'b1;
                end else if (w_done) begin
                    w_wait    = 1'b0;
                    w_cnt_dec = 1'b1;
                    if (w_cnt_last) begin
                        w_state    = ST_PP_DATA;
                        w_cnt_load = 1'b1;
                        w_cnt_val  = c_page_load;
                    end
                end
            end
            ST_PP_DATA: begin
                // buf_addr runs one byte ahead so the next read has settled by the next issue.
                if (!r_wait) begin
                    w_spi_start = 1'b1;
                    w_spi_tx    = buf_data;
                    w_buf_addr  = r_buf_addr + BUF_W'(1);
                    w_wait      = 1'b1;
                end else if (w_done) begin
                    w_wait    = 1'b0;
                    w_cnt_dec = 1'b1;
                    if (w_cnt_last) begin
                        w_ncs       = 1'b1;
                        w_state     = ST_GAP;
                        w_after_gap = ST_POLL_CMD;
                        w_cnt_load  = 1'b1;
                    end
                end
            end
            ST_POLL_CMD: begin
                if (!r_wait) begin
                    w_spi_start = 1'b1;
                    w_spi_tx    = c_opc_rdsr;
                    w_wait      = 1'b1;
                end else if (w_done) begin
                    w_state    = ST_POLL_RD;
                    w_wait     = 1'b0;
                    w_poll_cnt = '0;
                end
            end
            ST_POLL_RD: begin
                if (!r_wait) begin
                    w_spi_start = 1'b1;
                    w_spi_tx    = c_dummy;
                    w_wait      = 1'b1;
                end else if (w_done) begin
                    if (!spi.spi_rx[c_wip_bit]) begin
                        w_ncs   = 1'b1;
                        w_state = ST_NEXT;
                    end else if (w_poll_inc == c_poll_lim) begin
                        w_poll_cnt = w_poll_inc;
                        w_error    = 1'b1;
                        w_ncs      = 1'b1;
                        w_state    = ST_IDLE;
                    end else begin
                        w_poll_cnt = w_poll_inc;
                        w_wait     = 1'b0;
                    end
                end
            end
            ST_NEXT: begin
                w_page_done  = 1'b1;
                w_page_addr  = r_page_addr + ADDR_W'(PAGE_BYTES);
                w_pages_left = r_pages_left - 16'd1;
                if (r_pages_left == 16'd1) begin
                    w_state = ST_FINISH;
                end else begin
                    w_state     = ST_GAP;
                    w_after_gap = ST_WREN_TX;
                    w_cnt_load  = 1'b1;
                end
            end
            ST_FINISH: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
                w_ncs   = 1'b1;
            end
        endcase

        // busy lingers through the IDLE-entry cycle following FINISH.
        w_busy = (w_state != ST_IDLE) || (r_state == ST_FINISH);
    end

    assign spi.spi_start = r_spi_start;
    assign spi.spi_tx    = r_spi_tx;
    assign spi.nCS       = r_ncs;
    assign buf_addr      = r_buf_addr;
    assign page_done     = r_page_done;
    assign busy          = r_busy;
    assign error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_page_program_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_eeprom_page_program_ctrl
// Brief    : Directed bench with SPI device model and byte-stream scoreboard.
// Revision : 1.0
// ============================================================================
module tb_eeprom_page_program_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [23:0] base_addr = '0;
    logic [15:0] num_pages = '0;
    logic [3:0]  buf_addr;
    logic [7:0]  buf_data = '0;
    logic        page_done, busy, error;
    logic [7:0]  mem [16];

    eeprom_page_program_ctrl_if spi_if ();

    eeprom_page_program_ctrl #(
        .ADDR_BYTES (3),
        .PAGE_BYTES (16),
        .POLL_LIMIT (4),
        .CS_GAP     (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_pages (num_pages),
        .spi       (spi_if),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .page_done (page_done),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) buf_data <= mem[buf_addr];

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] log_q[$];
    logic [7:0] exp_q[$];
    logic       wip_q[$];
    logic       wip_default = 1'b0;
    int         gap_q[$];
    int         hi_run = 0, pd_cnt = 0, start_cnt = 0, low_cnt = 0, viol_cnt = 0, pend = 0;
    logic       prev_ncs = 1'b1, first_byte = 1'b1, wip_bit;
    logic [7:0] opcode = '0;

    // SPI device model: two-cycle transfer latency, status bytes from wip_q then wip_default.
    initial begin
        spi_if.spi_done = 1'b0;
        spi_if.spi_rx   = 8'h00;
        forever begin
            @(negedge clk);
            spi_if.spi_done = 1'b0;
            if (page_done === 1'b1) pd_cnt++;
            if (spi_if.nCS !== 1'b0) begin
                hi_run++;
                first_byte = 1'b1;
            end else begin
                low_cnt++;
                if (prev_ncs) begin
                    gap_q.push_back(hi_run);
                    hi_run = 0;
                end
            end
            if (rst) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) spi_if.spi_done = 1'b1;
            end else if (spi_if.spi_start === 1'b1) begin
                start_cnt++;
                if (spi_if.nCS !== 1'b0 || prev_ncs) viol_cnt++;
                log_q.push_back(spi_if.spi_tx);
                spi_if.spi_rx = 8'hFF;
                if (first_byte) begin
                    opcode     = spi_if.spi_tx;
                    first_byte = 1'b0;
                end else if (opcode == 8'h05) begin
                    if (wip_q.size() > 0) wip_bit = wip_q.pop_front();
                    else                  wip_bit = wip_default;
                    spi_if.spi_rx = {7'h00, wip_bit};
                end
                pend = 2;
            end
            prev_ncs = (spi_if.nCS !== 1'b0);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        #1;
        log_q.delete();
        exp_q.delete();
        gap_q.delete();
        wip_q.delete();
        pd_cnt = 0; start_cnt = 0; low_cnt = 0; viol_cnt = 0; hi_run = 0;
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] n);
        @(negedge clk);
        base_addr = a;
        num_pages = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic add_page(input logic [23:0] a, input int reads);
        exp_q.push_back(8'h06);
        exp_q.push_back(8'h02);
        exp_q.push_back(a[23:16]);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        for (int i = 0; i < 16; i++) exp_q.push_back(8'hA0 + 8'(i));
        exp_q.push_back(8'h05);
        for (int i = 0; i < reads; i++) exp_q.push_back(8'h00);
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, log_q[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ncs",       {31'd0, spi_if.nCS},       32'd1);
        check("rst_spi_start", {31'd0, spi_if.spi_start}, 32'd0);
        check("rst_spi_tx",    {24'd0, spi_if.spi_tx},    32'd0);
        check("rst_buf_addr",  {28'd0, buf_addr},         32'd0);
        check("rst_page_done", {31'd0, page_done},        32'd0);
        check("rst_busy",      {31'd0, busy},             32'd0);
        check("rst_error",     {31'd0, error},            32'd0);

        // Two pages, WIP busy for two reads on the first page, stray start while busy.
        clear_mon();
        wip_default = 1'b0;
        wip_q.push_back(1'b1);
        wip_q.push_back(1'b1);
        add_page(24'h000100, 3);
        add_page(24'h000110, 1);
        pulse_start(24'h000100, 16'd2);
        repeat (4) @(negedge clk);
        pulse_start(24'hABCDEF, 16'd5);
        wait_idle("pp_busy_end");
        cmp_stream("pp");
        check("pp_pages",     pd_cnt, 2);
        check("pp_gap_wren1", (gap_q.size() > 1) ? gap_q[1] : -1, 2);
        check("pp_gap_wren2", (gap_q.size() > 4) ? gap_q[4] : -1, 2);
        check("pp_cs_order",  viol_cnt, 0);
        check("pp_error",     {31'd0, error}, 32'd0);

        // Zero pages.
        clear_mon();
        pulse_start(24'h000000, 16'd0);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("zero_busy_cycles", n, 2);
        repeat (3) @(negedge clk);
        check("zero_spi_start", start_cnt, 0);
        check("zero_ncs_low",   low_cnt, 0);

        // Address wrap.
        clear_mon();
        wip_default = 1'b0;
        add_page(24'hFFFFF0, 1);
        add_page(24'h000000, 1);
        pulse_start(24'hFFFFF0, 16'd2);
        wait_idle("wrap_busy_end");
        cmp_stream("wrap");
        check("wrap_pages", pd_cnt, 2);

        // Poll timeout with WIP stuck high, then recovery.
        clear_mon();
        wip_default = 1'b1;
        add_page(24'h000200, 4);
        pulse_start(24'h000200, 16'd1);
        wait_idle("to_busy_end");
        cmp_stream("to");
        check("to_error", {31'd0, error},      32'd1);
        check("to_ncs",   {31'd0, spi_if.nCS}, 32'd1);
        check("to_pages", pd_cnt, 0);
        clear_mon();
        wip_default = 1'b0;
        add_page(24'h000300, 1);
        pulse_start(24'h000300, 16'd1);
        check("to_error_cleared", {31'd0, error}, 32'd0);
        wait_idle("rec_busy_end");
        cmp_stream("rec");
        check("rec_pages", pd_cnt, 1);
        check("rec_error", {31'd0, error}, 32'd0);

        // Reset while the eighth data byte is in flight.
        clear_mon();
        pulse_start(24'h000400, 16'd1);
        n = 0;
        while (log_q.size() < 13 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("mid_wait_byte7", log_q.size(), 13);
        check("mid_byte7_val", (log_q.size() > 12) ? {24'd0, log_q[12]} : 32'hFFFF, 32'hA7);
        rst = 1'b1;
        #1;
        check("mid_ncs",       {31'd0, spi_if.nCS},       32'd1);
        check("mid_spi_start", {31'd0, spi_if.spi_start}, 32'd0);
        check("mid_spi_tx",    {24'd0, spi_if.spi_tx},    32'd0);
        check("mid_buf_addr",  {28'd0, buf_addr},         32'd0);
        check("mid_page_done", {31'd0, page_done},        32'd0);
        check("mid_busy",      {31'd0, busy},             32'd0);
        check("mid_error",     {31'd0, error},            32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        clear_mon();
        add_page(24'h000500, 1);
        pulse_start(24'h000500, 16'd1);
        wait_idle("post_busy_end");
        cmp_stream("post");
        check("post_pages", pd_cnt, 1);
        check("post_cs_order", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eeprom_page_program_ctrl.md
# eeprom_page_program_ctrl

Parametrised SPI EEPROM/flash page-program controller for the logger's storage path. Sits between the sample page buffer and the byte-level SPI master. For each page it issues WREN, then Page Program with a multi-byte address and PAGE_BYTES data bytes, then polls the status register until the write completes. It programs N consecutive pages from a start address and flags a timeout error if the device never goes idle.

## Interface
- ADDR_BYTES, 3: device address length in bytes (2 or 3).
- PAGE_BYTES, 256: data bytes per page (power of 2, 16..256).
- POLL_LIMIT, 65535: maximum RDSR polls per page before error.
- CS_GAP, 2: minimum nCS-high cycles between commands (≥1).
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begin sequence (ignored while busy=1)
- base_addr  in  8*ADDR_BYTES  first page address, sampled on start
- num_pages  in  16  pages to program, sampled on start
- spi_start  out  1  one-cycle pulse; SPI master transfers spi_tx
- spi_tx  out  8  byte to send, stable from spi_start until spi_done
- spi_done  in  1  one-cycle pulse; transfer finished, spi_rx valid
- spi_rx  in  8  received byte
- nCS  out  1  device chip select, active-low
- buf_addr  out  log2(PAGE_BYTES)  page-buffer read address
- buf_data  in  8  page-buffer data, one-cycle read latency
- page_done  out  1  one-cycle pulse per page completed (after WIP clear)
- busy  out  1  high from the cycle after start until return to IDLE
- error  out  1  sticky poll-timeout flag; cleared by the next accepted start

## Operation
- Opcodes: WREN 0x06, PP 0x02, RDSR 0x05; WIP is status bit 0.
- States: IDLE, GAP, WREN_TX, PP_CMD, PP_ADDR, PP_DATA, POLL_CMD, POLL_RD, NEXT, FINISH.
- IDLE: on start, latch base_addr into page_addr and num_pages into pages_left, clear error. If num_pages==0, go to FINISH (no SPI activity). Otherwise go to GAP, then WREN_TX.
- Each TX state: assert nCS=0, pulse spi_start, wait for spi_done.
- WREN_TX: send 0x06, then GAP (nCS=1 for CS_GAP cycles).
- PP_CMD: send 0x02.
- PP_ADDR: send page_addr MSB first, ADDR_BYTES bytes.
- PP_DATA: send buf_data for buf_addr = 0..PAGE_BYTES-1, then GAP.
- POLL_CMD: send 0x05.
- POLL_RD: send 0x00 dummy byte. If spi_rx[0]==0, go to NEXT. If spi_rx[0]==1, send another dummy byte (nCS held low) and increment poll_cnt.
- Poll timeout: when poll_cnt reaches POLL_LIMIT, set error, force nCS=1 and go to IDLE. page_done is not pulsed.
- NEXT: pulse page_done, page_addr += PAGE_BYTES (wraps modulo 2^(8*ADDR_BYTES)), decrement pages_left. If pages_left is now 0, go to FINISH; else go to GAP then WREN_TX.
- FINISH: one cycle, then IDLE (busy falls).
- buf_addr resets to 0 per page; the internal byte counter is log2(PAGE_BYTES)+1 bits wide to detect the end of the page.

## Timing
- Reset values: nCS=1, spi_start=0, spi_tx=0, buf_addr=0, page_done=0, busy=0, error=0, state IDLE.
- Reset mid-operation: nCS high immediately (asynchronous) and the sequence is abandoned.
- nCS falls one cycle before the first spi_start of a command. nCS rises the cycle after the last spi_done of that command.
- A new spi_start is issued no earlier than 1 cycle after spi_done.
- buf_addr is set ≥1 cycle before the spi_start that sends its byte.
- A spi_done arriving while no transfer is outstanding is ignored.
- start is ignored while busy=1; no error is raised for it.
- spi_done coinciding with rst: rst wins.
- All outputs are registered.

## Structure
- Shared package holds the opcode constants, the WIP bit index, and the state enum.
- One sub-module, spi_cmd_seq_cnt: byte counter and CS_GAP timer with load/terminal-count outputs, shared by all phases.

## Test plan
- Pages and addressing: ADDR_BYTES=3, PAGE_BYTES=16, base 0x000100, num_pages=2, model returns WIP=1 twice then 0 → byte stream 06 / 02 00 01 00 d0..d15 / 05 00 00 00 / 06 / 02 00 01 10 ...; two page_done pulses; busy then falls.
- Zero pages: num_pages=0 → no spi_start and nCS stays 1; busy high for 2 cycles.
- Address wrap: base 0xFFFFF0, PAGE_BYTES=16, 2 pages → second page address 0x000000.
- Poll timeout: POLL_LIMIT=4, WIP stuck 1 → error=1, nCS=1, no page_done, return to IDLE; the next start clears error.
- Reset mid-PP_DATA: assert rst at byte 7 → nCS=1 in the same cycle; all outputs at reset values; a following start completes normally.
- Busy and gap: start pulsed while busy is ignored; nCS stays high for exactly CS_GAP cycles between WREN and PP.
